// File: rtl/mult_div_unit_if.sv
// mult_div_unit_if: request/response bundle between the E stage and the
// multiply/divide unit.
//   start  - request strobe, meaningful only with a nonzero md_op
//   md_op  - 000 none, 001 mult, 010 multu, 011 div, 100 divu,
//            101 mthi, 110 mtlo, 111 reserved
//   src_a  - forwarded rs operand
//   src_b  - forwarded rt operand
//   busy   - registered, high while a multiply or divide is in flight
//   hi/lo  - registered HI and LO architectural registers
// master: the pipeline side; slave: the unit itself.
interface mult_div_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: HI/LO multiply/divide unit with a fixed, parameterised
// latency per operation class.
//   clk   - sole clock, rising edge
//   reset - synchronous, active-low
//   bus   - mult_div_unit_if.slave (start, md_op, src_a, src_b in;
//           busy, hi, lo out, all outputs registered)
// The 64-bit result is computed when the request is accepted and held in
// result_r; the busy period only models the pipeline-visible latency.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  mult_div_unit_if.slave   bus
);

  localparam logic [2:0] OP_MULT  = 3'b001;
  localparam logic [2:0] OP_MULTU = 3'b010;
  localparam logic [2:0] OP_DIV   = 3'b011;
  localparam logic [2:0] OP_DIVU  = 3'b100;
  localparam logic [2:0] OP_MTHI  = 3'b101;
  localparam logic [2:0] OP_MTLO  = 3'b110;

  localparam logic [3:0] MULT_LAT = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_LAT  = 4'(DIV_CYCLES);

  typedef enum logic [0:0] {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t      state_r, state_nxt;
  logic [3:0]  cnt_r, cnt_nxt;
  logic        busy_r, busy_nxt;
  logic [31:0] hi_r, hi_nxt;
  logic [31:0] lo_r, lo_nxt;
  logic [63:0] result_r, result_nxt;
  logic        commit_r, commit_nxt;

  logic [63:0] smul_s, umul_s;
  logic [31:0] abs_a_s, abs_b_s, q_mag_s, r_mag_s;
  logic [31:0] quo_s, rem_s, uquo_s, urem_s;
  logic        div_zero_s;

  // Arithmetic datapath: products and quotients from the current operands.
  // Signed division works on magnitudes so that 0x80000000 / -1 needs no
  // special case: the magnitude 2^31 wraps back to 0x80000000.
  always_comb begin
    smul_s     = {{32{bus.src_a[31]}}, bus.src_a} * {{32{bus.src_b[31]}}, bus.src_b};
    umul_s     = {32'd0, bus.src_a} * {32'd0, bus.src_b};
    div_zero_s = (bus.src_b == 32'd0);
    abs_a_s    = bus.src_a[31] ? (32'd0 - bus.src_a) : bus.src_a;
    abs_b_s    = bus.src_b[31] ? (32'd0 - bus.src_b) : bus.src_b;
    if (div_zero_s) begin
      q_mag_s = 32'd0;
      r_mag_s = 32'd0;
      uquo_s  = 32'd0;
      urem_s  = 32'd0;
    end else begin
      q_mag_s = abs_a_s / abs_b_s;
      r_mag_s = abs_a_s % abs_b_s;
      uquo_s  = bus.src_a / bus.src_b;
      urem_s  = bus.src_a % bus.src_b;
    end
    quo_s = (bus.src_a[31] ^ bus.src_b[31]) ? (32'd0 - q_mag_s) : q_mag_s;
    rem_s = bus.src_a[31] ? (32'd0 - r_mag_s) : r_mag_s;
  end

  // Next-state and next-output logic for the IDLE/RUN controller.
  always_comb begin
    state_nxt  = state_r;
    cnt_nxt    = cnt_r;
    busy_nxt   = busy_r;
    hi_nxt     = hi_r;
    lo_nxt     = lo_r;
    result_nxt = result_r;
    commit_nxt = commit_r;
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          case (bus.md_op)
            OP_MULT: begin
              result_nxt = smul_s;
              commit_nxt = 1'b1;
              cnt_nxt    = MULT_LAT;
              busy_nxt   = 1'b1;
              state_nxt  = RUN;
            end
            OP_MULTU: begin
              result_nxt = umul_s;
              commit_nxt = 1'b1;
              cnt_nxt    = MULT_LAT;
              busy_nxt   = 1'b1;
              state_nxt  = RUN;
            end
            OP_DIV: begin
              result_nxt = {rem_s, quo_s};
              commit_nxt = ~div_zero_s;
              cnt_nxt    = DIV_LAT;
              busy_nxt   = 1'b1;
              state_nxt  = RUN;
            end
            OP_DIVU: begin
              result_nxt = {urem_s, uquo_s};
              commit_nxt = ~div_zero_s;
              cnt_nxt    = DIV_LAT;
              busy_nxt   = 1'b1;
              state_nxt  = RUN;
            end
            OP_MTHI: hi_nxt = bus.src_a;
            OP_MTLO: lo_nxt = bus.src_a;
            default: begin
              // none / reserved: nothing changes
            end
          endcase
        end else begin
          // no request
        end
      end
      RUN: begin
        // New requests are ignored here; the hazard unit stalls on start|busy.
        cnt_nxt = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          cnt_nxt   = 4'd0;
          busy_nxt  = 1'b0;
          state_nxt = IDLE;
          if (commit_r) begin
            hi_nxt = result_r[63:32];
            lo_nxt = result_r[31:0];
          end else begin
            // divide by zero: HI/LO keep their values
          end
        end else begin
          // still counting
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = 4'd0;
        busy_nxt  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      busy_r   <= 1'b0;
      hi_r     <= 32'd0;
      lo_r     <= 32'd0;
      result_r <= 64'd0;
      commit_r <= 1'b0;
    end else begin
      state_r  <= state_nxt;
      cnt_r    <= cnt_nxt;
      busy_r   <= busy_nxt;
      hi_r     <= hi_nxt;
      lo_r     <= lo_nxt;
      result_r <= result_nxt;
      commit_r <= commit_nxt;
    end
  end

  assign bus.busy = busy_r;
  assign bus.hi   = hi_r;
  assign bus.lo   = lo_r;

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: self-checking bench for mult_div_unit. Expected HI/LO
// pairs and busy lengths are pushed to scoreboard queues when a request is
// driven and popped when busy drops.
module tb_mult_div_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  logic [63:0] sb_q[$];
  int          cyc_q[$];
  logic [31:0] m_hi, m_lo;

  mult_div_unit_if mif();

  mult_div_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model of one accepted request on the architectural HI/LO pair.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] h,
                                        input logic [31:0] l);
    logic signed [63:0] sa, sb;
    logic signed [31:0] q, r;
    logic [63:0] res;
    res = {h, l};
    case (op)
      3'd1: begin sa = $signed(a); sb = $signed(b); res = sa * sb; end
      3'd2: res = {32'd0, a} * {32'd0, b};
      3'd3: begin
        if (b == 32'd0) res = {h, l};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = {32'd0, 32'h8000_0000};
        else begin
          q = $signed(a) / $signed(b);
          r = $signed(a) % $signed(b);
          res = {r, q};
        end
      end
      3'd4: res = (b == 32'd0) ? {h, l} : {a % b, a / b};
      3'd5: res = {a, l};
      3'd6: res = {h, a};
      default: res = {h, l};
    endcase
    return res;
  endfunction

  function automatic int lat(input logic [2:0] op);
    if (op == 3'd1 || op == 3'd2) return 5;
    if (op == 3'd3 || op == 3'd4) return 10;
    return 0;
  endfunction

  // Issue one request, optionally re-strobe start mid-run, then compare.
  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input bit inject);
    logic [63:0] exp;
    int cyc;
    exp = model(op, a, b, m_hi, m_lo);
    {m_hi, m_lo} = exp;
    sb_q.push_back(exp);
    cyc_q.push_back(lat(op));
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = op; mif.src_a = a; mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 3'd0; mif.src_a = $urandom; mif.src_b = $urandom;
    cyc = 0;
    while (mif.busy && cyc < 40) begin
      cyc++;
      if (inject && cyc == 2) begin
        mif.start = 1'b1; mif.md_op = 3'd1; mif.src_a = 32'd100; mif.src_b = 32'd100;
      end else begin
        mif.start = 1'b0; mif.md_op = 3'd0;
      end
      @(negedge clk);
    end
    mif.start = 1'b0;
    if (sb_q.size() == 0 || cyc_q.size() == 0) begin
      check({tag, "_sb_empty"}, 64'd1, 64'd0);
    end else begin
      check({tag, "_busy_cycles"}, 64'(cyc), 64'(cyc_q.pop_front()));
      check({tag, "_hilo"}, {mif.hi, mif.lo}, sb_q.pop_front());
    end
  endtask

  initial begin
    logic [2:0] rop;
    logic [31:0] ra, rb;
    n_checks = 0;
    n_errors = 0;
    reset = 1'b0;
    mif.start = 1'b0; mif.md_op = 3'd0; mif.src_a = 32'd0; mif.src_b = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    check("reset_hi", {32'd0, mif.hi}, 64'd0);
    check("reset_lo", {32'd0, mif.lo}, 64'd0);
    check("reset_busy", {63'd0, mif.busy}, 64'd0);

    run_op("mult_neg", 3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
    run_op("multu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("div_neg", 3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0);
    run_op("mtlo", 3'd6, 32'h0000_1234, 32'd0, 1'b0);
    run_op("divu_zero", 3'd4, 32'd7, 32'd0, 1'b0);
    run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mthi", 3'd5, 32'hDEAD_BEEF, 32'd0, 1'b0);
    run_op("mult_inject", 3'd1, 32'd6, 32'd7, 1'b1);
    run_op("div_zero", 3'd3, 32'd9, 32'd0, 1'b0);

    // Reserved and none opcodes with start must leave everything unchanged.
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = 3'd7; mif.src_a = 32'h1111_1111;
    @(negedge clk);
    mif.md_op = 3'd0;
    @(negedge clk);
    mif.start = 1'b0;
    repeat (2) @(negedge clk);
    check("reserved_busy", {63'd0, mif.busy}, 64'd0);
    check("reserved_hilo", {mif.hi, mif.lo}, {m_hi, m_lo});

    // Mixed random requests.
    for (int i = 0; i < 10; i++) begin
      rop = 3'($urandom_range(1, 6));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom;
      run_op("random", rop, ra, rb, 1'b0);
    end

    // Reset on the 3rd busy cycle of a mult, with a simultaneous mthi start.
    run_op("pre_abort", 3'd5, 32'hCAFE_F00D, 32'd0, 1'b0);
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = 3'd1; mif.src_a = 32'd1000; mif.src_b = 32'd1000;
    @(negedge clk);
    mif.start = 1'b0; mif.md_op = 3'd0;
    check("abort_busy_started", {63'd0, mif.busy}, 64'd1);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    mif.start = 1'b1; mif.md_op = 3'd5; mif.src_a = 32'h5555_5555;
    @(negedge clk);
    reset = 1'b1;
    mif.start = 1'b0; mif.md_op = 3'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    check("abort_busy", {63'd0, mif.busy}, 64'd0);
    check("abort_hilo", {mif.hi, mif.lo}, 64'd0);
    repeat (10) @(negedge clk);
    check("abort_no_commit", {mif.hi, mif.lo}, 64'd0);
    check("abort_busy_late", {63'd0, mif.busy}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, multiply latency in cycles (legal range 1-15).
REQ-002 Parameter DIV_CYCLES, default 10, divide latency in cycles (legal range 1-15).
REQ-003 CLK  input  1  sole clock; all state updates on its rising edge.
REQ-004 Reset  input  1  synchronous, active-low reset; sampled on the CLK rising edge.
REQ-005 Start  input  1  request strobe from the E stage; valid only with a nonzero MD_Op.
REQ-006 MD_Op  input  3  operation: 000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved.
REQ-007 SrcA  input  32  forwarded rs operand from the E stage.
REQ-008 SrcB  input  32  forwarded rt operand from the E stage.
REQ-009 Busy  output  1  registered; high while a multiply or divide is in flight.
REQ-010 HI  output  32  registered HI register.
REQ-011 LO  output  32  registered LO register.

Function
REQ-012 FSM states: IDLE and RUN; a 4-bit down-counter CNT and a latched op/result pair live alongside the FSM.
REQ-013 IDLE with Start=1 and MD_Op in {mult, multu, div, divu}: latch the op, compute the 64-bit result from SrcA/SrcB, load CNT with the op latency, go to RUN, and assert Busy=1 from the next cycle.
REQ-014 RUN: decrement CNT every cycle. When CNT reaches 1, commit the result to HI/LO on that edge, clear Busy, and return to IDLE.
REQ-015 Busy stays high for exactly MULT_CYCLES or DIV_CYCLES cycles. The new HI/LO value is visible in the first cycle with Busy=0.
REQ-016 HI/LO hold their previous values throughout RUN.
REQ-017 mult: signed 32x32 to 64-bit product; HI = bits[63:32], LO = bits[31:0]. multu: the same, unsigned.
REQ-018 div: signed division; LO = quotient truncated toward zero, HI = remainder with the sign of the dividend. divu: unsigned division.
REQ-019 div with SrcA=0x80000000 and SrcB=0xFFFFFFFF: LO=0x80000000, HI=0x00000000.
REQ-020 Divisor zero (div or divu): run the full DIV_CYCLES busy period, then leave HI/LO unchanged.
REQ-021 mthi / mtlo with Start=1 in IDLE: write SrcA to HI / LO on that edge. Busy is not asserted and the state stays IDLE.
REQ-022 Start while in RUN: ignored; the in-flight operation completes unaffected. The hazard unit stalls on Start|Busy, so this does not occur in normal operation.
REQ-023 Start=1 with MD_Op none or reserved: no state change.
REQ-024 Start=0: MD_Op, SrcA and SrcB are don't-care.
REQ-025 HI and LO are driven only from their registers; there is no combinational path from any input to HI, LO or Busy.

Reset
REQ-026 Reset=0 at a CLK edge: HI=0, LO=0, Busy=0, CNT=0, state IDLE, regardless of the current state.
REQ-027 Reset mid-RUN aborts the operation; the pending result is never committed.
REQ-028 Reset=0 overrides a simultaneous Start.

Verification
REQ-029 Directed: mult with SrcA=0xFFFFFFFE (-2), SrcB=3 -> Busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-030 Directed: multu with SrcA=0xFFFFFFFF, SrcB=0xFFFFFFFF -> after 5 busy cycles, HI=0xFFFFFFFE, LO=0x00000001.
REQ-031 Directed: div with SrcA=-7, SrcB=2 -> Busy high for 10 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). divu with SrcA=7, SrcB=0 after mtlo 0x1234 -> LO stays 0x1234.
REQ-032 Directed: div with SrcA=0x80000000, SrcB=0xFFFFFFFF -> LO=0x80000000, HI=0.
REQ-033 Directed: mthi with SrcA=0xDEADBEEF -> HI=0xDEADBEEF one edge later and Busy never rises. A second Start(mult) issued during RUN -> ignored; the first result is committed unchanged.
REQ-034 Directed: Reset=0 on the 3rd busy cycle of a mult -> HI=LO=0 and Busy=0 on the next edge, with no later commit.
